// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU.
// Contents:
//   alu_op_e  - 3-bit operation encodings (OP_AND .. OP_PASSA)
//   init_flag - flag value that is injected at bit 0 of every word
//   maj       - three-input majority, used for the carry/borrow chain
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_ADD   = 3'b011,
    OP_SUB   = 3'b100,
    OP_NAND  = 3'b101,
    OP_EQ    = 3'b110,
    OP_PASSA = 3'b111
  } alu_op_e;

  // SUB starts with carry-in 1 (two's complement of B); EQ starts as "equal so far".
  // Every other op starts with a cleared carry or nonzero flag.
  function automatic logic init_flag(input alu_op_e op);
    return (op == OP_SUB) || (op == OP_EQ);
  endfunction

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational single-bit ALU slice.
// Ports:
//   a, b - operand bits for the current position
//   cin  - effective flag-in (INIT value at bit 0, stored flag otherwise)
//   op   - operation select
//   r    - result bit
//   nf   - next flag value (carry, borrow, nonzero or equality)
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_e op,
  output logic    r,
  output logic    nf
);

  always_comb begin
    r  = 1'b0;
    nf = 1'b0;
    unique case (op)
      OP_AND: begin
        r  = a & b;
        nf = cin | r;
      end
      OP_OR: begin
        r  = a | b;
        nf = cin | r;
      end
      OP_XOR: begin
        r  = a ^ b;
        nf = cin | r;
      end
      OP_ADD: begin
        r  = a ^ b ^ cin;
        nf = maj(a, b, cin);
      end
      // A + ~B + 1: final carry of 1 means no borrow.
      OP_SUB: begin
        r  = a ^ ~b ^ cin;
        nf = maj(a, ~b, cin);
      end
      OP_NAND: begin
        r  = ~(a & b);
        nf = cin | r;
      end
      // Flag stays 1 only while every bit pair has matched.
      OP_EQ: begin
        r  = ~(a ^ b);
        nf = cin & r;
      end
      OP_PASSA: begin
        r  = a;
        nf = cin | r;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Bit-serial ALU: one bit of A and B per clock, LSB first, WIDTH bits per word.
// A single flag register carries carry/borrow/nonzero/equality between bits.
// Ports:
//   reclk  - system clock, rising edge
//   rst    - synchronous active-low reset
//   ain    - operand A bit
//   bin    - operand B bit
//   op     - operation select, held for a whole word
//   aluout - result bit for the current position
//   regout - registered flag; holds the word's final status after its last bit
// Optional build macro:
//   ALU_OUTREG_EN - when defined, aluout is registered (one clock of latency,
//                   resets to 0); otherwise aluout is combinational.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       reclk,
  input  logic       rst,
  input  logic       ain,
  input  logic       bin,
  input  logic [2:0] op,
  output logic       aluout,
  output logic       regout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

  alu_op_e       op_sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q;
  logic          cin;
  logic          r;
  logic          nf;

  assign op_sel = alu_op_e'(op);

  // Bit 0 ignores the previous word's flag so words can run back to back.
  assign cin = (cnt_q == '0) ? init_flag(op_sel) : flag_q;

  alu_bit_slice u_slice (
    .a   (ain),
    .b   (bin),
    .cin (cin),
    .op  (op_sel),
    .r   (r),
    .nf  (nf)
  );

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge reclk) begin
    if (!rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= nf;
    end
  end

  assign regout = flag_q;

`ifdef ALU_OUTREG_EN
  logic aluout_q;

  always_ff @(posedge reclk) begin
    if (!rst) begin
      aluout_q <= 1'b0;
    end else begin
      aluout_q <= r;
    end
  end

  assign aluout = aluout_q;
`else
  assign aluout = r;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the bit-serial ALU at WIDTH=4 (combinational aluout).
// Expected word results come from whole-word arithmetic, pushed to a queue per
// word and popped bit by bit as the DUT produces them.
module tb_alu;
  import alu_pkg::*;

  localparam int unsigned W = 4;

  logic       reclk;
  logic       rst;
  logic       ain;
  logic       bin;
  logic [2:0] op;
  logic       aluout;
  logic       regout;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  logic prev_flag;
  bit   prev_valid;

  alu #(.WIDTH(W)) dut (
    .reclk  (reclk),
    .rst    (rst),
    .ain    (ain),
    .bin    (bin),
    .op     (op),
    .aluout (aluout),
    .regout (regout)
  );

  initial begin
    reclk = 1'b0;
    forever #5 reclk = ~reclk;
  end

  // Whole-word reference: result bits and final flag.
  task automatic model(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                       output logic [3:0] res, output logic flg);
    logic [4:0] sum;
    case (o)
      OP_AND:  begin res = a & b;     flg = |res;        end
      OP_OR:   begin res = a | b;     flg = |res;        end
      OP_XOR:  begin res = a ^ b;     flg = |res;        end
      OP_ADD:  begin sum = {1'b0, a} + {1'b0, b}; res = sum[3:0]; flg = sum[4]; end
      OP_SUB:  begin res = a - b;     flg = (a >= b);    end
      OP_NAND: begin res = ~(a & b);  flg = |res;        end
      OP_EQ:   begin res = ~(a ^ b);  flg = (a == b);    end
      default: begin res = a;         flg = |res;        end
    endcase
  endtask

  // Called at posedge+1; leaves at posedge+1 after the word's last bit.
  task automatic run_word(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                          input string name);
    logic [3:0] res;
    logic       flg;
    logic       e;
    model(o, a, b, res, flg);
    for (int i = 0; i < W; i++) exp_q.push_back(res[i]);
    for (int i = 0; i < W; i++) begin
      op  = o;
      ain = a[i];
      bin = b[i];
      #2;
      if (i == 0 && prev_valid) begin
        checks++;
        if (regout !== prev_flag) begin
          errors++;
          $display("FAIL %s hold regout got %b want %b", name, regout, prev_flag);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if (aluout !== e) begin
        errors++;
        $display("FAIL %s aluout bit %0d got %b want %b", name, i, aluout, e);
      end
      @(posedge reclk);
      #1;
    end
    checks++;
    if (regout !== flg) begin
      errors++;
      $display("FAIL %s final regout got %b want %b", name, regout, flg);
    end
    prev_flag  = flg;
    prev_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic e;
    rst = 1'b0;
    op  = OP_ADD;
    ain = 1'b1;
    bin = 1'b1;
    @(posedge reclk);
    @(posedge reclk);
    #1;
    checks++;
    if (regout !== 1'b0) begin
      errors++;
      $display("FAIL reset regout got %b want 0", regout);
    end
    // Word is 1 + 1 = 2 (0010), final carry 0.
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    rst = 1'b1;
    for (int i = 0; i < W; i++) begin
      ain = (i == 0);
      bin = (i == 0);
      #2;
      e = exp_q.pop_front();
      checks++;
      if (aluout !== e) begin
        errors++;
        $display("FAIL reset_word aluout bit %0d got %b want %b", i, aluout, e);
      end
      @(posedge reclk);
      #1;
      if (i == 0) begin
        checks++;
        if (regout !== 1'b1) begin
          errors++;
          $display("FAIL reset_first_carry regout got %b want 1", regout);
        end
      end
    end
    checks++;
    if (regout !== 1'b0) begin
      errors++;
      $display("FAIL reset_word final regout got %b want 0", regout);
    end
    prev_flag  = 1'b0;
    prev_valid = 1'b1;
  endtask

  task automatic test_add();
    run_word(OP_ADD, 4'd15, 4'd1, "add_15_1");
    run_word(OP_ADD, 4'd3, 4'd1, "add_3_1");
    run_word(OP_ADD, 4'd9, 4'd6, "add_9_6");
  endtask

  task automatic test_sub();
    run_word(OP_SUB, 4'd5, 4'd3, "sub_5_3");
    run_word(OP_SUB, 4'd3, 4'd5, "sub_3_5");
    run_word(OP_SUB, 4'd7, 4'd7, "sub_7_7");
  endtask

  task automatic test_logic();
    run_word(OP_AND, 4'b1100, 4'b1010, "and");
    run_word(OP_AND, 4'b0101, 4'b1010, "and_zero");
    run_word(OP_OR, 4'b0100, 4'b0001, "or");
    run_word(OP_XOR, 4'b0110, 4'b0110, "xor_zero");
    run_word(OP_XOR, 4'b1001, 4'b0011, "xor");
    run_word(OP_NAND, 4'b1111, 4'b1111, "nand_zero");
    run_word(OP_NAND, 4'b1011, 4'b0110, "nand");
    run_word(OP_PASSA, 4'b1000, 4'b0111, "passa");
  endtask

  task automatic test_back_to_back();
    run_word(OP_EQ, 4'd6, 4'd6, "eq_6_6");
    run_word(OP_EQ, 4'd6, 4'd7, "eq_6_7");
    run_word(OP_EQ, 4'd6, 4'd6, "eq_6_6_again");
    run_word(OP_ADD, 4'd8, 4'd8, "add_carry_out");
    run_word(OP_ADD, 4'd1, 4'd0, "add_after_carry");
  endtask

  task automatic test_midword_reset();
    op  = OP_ADD;
    ain = 1'b1;
    bin = 1'b1;
    @(posedge reclk);
    #1;
    @(posedge reclk);
    #1;
    rst = 1'b0;
    @(posedge reclk);
    #1;
    checks++;
    if (regout !== 1'b0) begin
      errors++;
      $display("FAIL midreset regout got %b want 0", regout);
    end
    rst        = 1'b1;
    prev_valid = 1'b0;
    // SUB relies on INIT=1 at bit 0, so a counter that did not restart shows up here.
    run_word(OP_SUB, 4'd5, 4'd3, "midreset_sub");
    run_word(OP_ADD, 4'd15, 4'd1, "midreset_add");
  endtask

  initial begin
    prev_valid = 1'b0;
    prev_flag  = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_midword_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Bit-serial ALU. Processes one bit of A and B per clock, LSB first, over words of WIDTH bits.
- A single flag register carries state between bits: carry, borrow, nonzero or equality, depending on op.
- aluout is the result bit for the current bit position. regout is the registered flag; after the last bit of a word it holds the word's final carry or status.
- Sits between serial operand shift registers and a serial result sink in the datapath.

Parameters:
- WIDTH, 8, word length in bits; bit counter wraps at WIDTH-1. Legal range 2..64.

Ports:
- reclk  in  1  single system clock, rising-edge active.
- rst  in  1  synchronous active-low reset, sampled on rising reclk.
- ain  in  1  operand A bit, current position.
- bin  in  1  operand B bit, current position.
- op  in  3  operation select; hold constant for a whole word.
- aluout  out  1  result bit, combinational from ain, bin, op, cnt and flag.
- regout  out  1  flag register value.

Behaviour:
- Interface: one clock (reclk); reset is synchronous and active-low (rst).
- Reset: when rst=0 at a rising reclk, set cnt=0 and flag=0, so regout=0. Reset wins over all other activity, including mid-word; the word is abandoned and the next bit is treated as bit 0.
- Counter: cnt runs 0..WIDTH-1 and advances every non-reset clock. It wraps from WIDTH-1 to 0 with no gap cycle.
- Effective flag-in: cin = (cnt==0) ? INIT(op) : flag.
- Op decode (result bit r; next flag nf; INIT):
  - 000 AND: r=a&b; nf=cin|r; INIT 0 (nonzero flag).
  - 001 OR: r=a|b; nf=cin|r; INIT 0.
  - 010 XOR: r=a^b; nf=cin|r; INIT 0.
  - 011 ADD: r=a^b^cin; nf=maj(a,b,cin); INIT 0 (carry).
  - 100 SUB (A-B): r=a^~b^cin; nf=maj(a,~b,cin); INIT 1. Final flag 1 means no borrow (A>=B, unsigned).
  - 101 NAND: r=~(a&b); nf=cin|r; INIT 0.
  - 110 EQ: r=~(a^b); nf=cin&r; INIT 1. Final flag 1 means A==B.
  - 111 PASSA: r=a; nf=cin|r; INIT 0.
- Flag update: flag<=nf on every non-reset rising edge. aluout=r with zero latency.
- Word boundary: after the clock that consumes bit WIDTH-1, regout holds the final status. It stays valid throughout the following bit-0 cycle. The new word ignores the old flag through the INIT mux.
- Mid-word op change: the new op takes effect immediately with the current flag. No error is raised and the result is defined only by the rules above.
- No X propagation: any unlisted state is unreachable. cnt width is clog2(WIDTH).

Optional Feature:
- ALU_OUTREG_EN.
- Defined: aluout is registered and lags the input bit by one clock. It resets to 0, and regout is unchanged.
- Undefined: aluout is combinational with zero latency.

Decomposition:
- Package alu_pkg holds:
  - op encodings as localparams/enum: OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_NAND, OP_EQ, OP_PASSA.
  - a function returning INIT(op).
- Sub-module alu_bit_slice: purely combinational (a, b, cin, op) -> (r, nf).
- The top level holds cnt, the flag register, the INIT mux and the optional output register.

Test Plan (WIDTH=4, bits listed LSB first, one bit per clock after rst released high):
- Reset: hold rst=0 for 2 clocks with a=b=1 and op=ADD -> regout=0, cnt=0. At the first clock after release, aluout=0 (1+1+0) and regout becomes 1.
- ADD 15+1: a=1,1,1,1; b=1,0,0,0 -> aluout=0,0,0,0; regout=1 after bit 3.
- ADD 3+1: a=1,1,0,0; b=1,0,0,0 -> aluout=0,0,1,0; final regout=0.
- SUB 5-3: a=1,0,1,0; b=1,1,0,0 -> aluout=0,1,0,0; final regout=1.
- SUB 3-5 -> aluout=0,1,1,1; final regout=0.
- EQ back-to-back words 6 vs 6 then 6 vs 7 -> final regout=1 after word 1, then 0 after word 2; bit 0 of word 2 uses INIT=1.
- Mid-word reset: during ADD, assert rst=0 at bit 2 -> flag=0, and the next bit after release is treated as bit 0.
